pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Next-generation program counter for the MIPS core. It is a parametrised PC register with stall hold, priority next-PC selection (exception, exception return, jump, subroutine return, branch, sequential) and address-space masking. It also contains a small return-address stack (RAS) and a two-state exception FSM that holds the EPC. It sits at the head of the fetch path; its output addresses instruction memory.

Parameters:
N, 32, datapath/PC width in bits
ADDR_BITS, 20, implemented address bits; every loaded PC value is {(N-ADDR_BITS)'b0, value[ADDR_BITS-1:0]}
RESET_VECTOR, 32'h0000_0000, PC value on reset (masked)
EXC_VECTOR, 32'h0000_0180, exception handler address (masked)
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  hold PC; blocks every update except exception
branch_taken  in  1  take branch_target
branch_target  in  N  branch destination
jump  in  1  take jump_target
jump_target  in  N  jump destination; also the fallback for ret on an empty RAS
call  in  1  push PCValue+4 onto the RAS (jal)
ret  in  1  return (jr $ra): pop the RAS and go to its top
exception  in  1  trap request
eret  in  1  return from exception
PCValue  out  N  current PC
EPCValue  out  N  saved exception PC
in_exception  out  1  FSM is in EXC
ras_empty  out  1  RAS count == 0
ras_full  out  1  RAS count == RAS_DEPTH

Behaviour:
- Reset (async, reset==0): PCValue=RESET_VECTOR masked; EPCValue=0; state=RUN; RAS count=0; ras_empty=1; ras_full=0; in_exception=0. Reset mid-operation aborts everything immediately.
- All updates occur on the rising edge of clk with reset==1. Latency is 1 cycle from inputs to PCValue.
- Next-PC priority, highest first:
  - exception (accepted only in RUN)
  - eret (accepted only in EXC)
  - ret
  - jump
  - branch_taken
  - sequential PCValue+4
- Sequential increment wraps inside the masked space: 0x000F_FFFC + 4 -> 0x0000_0000 (default parameters).
- stall=1: PC, RAS and FSM are held. Exception is the only exception to this: it is accepted even when stalled.
- FSM RUN -> EXC on exception: EPCValue<=PCValue, PCValue<=EXC_VECTOR, in_exception=1.
- FSM EXC -> RUN on eret (not stalled): PCValue<=EPCValue, in_exception=0.
- exception while in EXC: ignored. EPC is not overwritten and the request is treated as absent.
- eret while in RUN: ignored. The next PC falls through to the lower-priority sources.
- RAS push: call with PC advancing (no stall, no exception) pushes masked PCValue+4.
- RAS full: a push overwrites the oldest entry (circular); count stays at RAS_DEPTH.
- RAS pop: ret with PC advancing sets PCValue to the top entry and decrements count.
- ret on an empty RAS: PCValue<=jump_target masked; count stays 0.
- call and ret in the same cycle: pop then push. The target is the old top (or jump_target if empty); the top is replaced by PCValue+4; count is unchanged if nonempty, otherwise becomes 1.
- An exception that wins the cycle suppresses the call/ret RAS side effects. eret does not touch the RAS.
- Outputs are registered (PCValue, EPCValue) or decoded from registered state (flags). There are no combinational input-to-output paths.

Test Plan:
- Reset then 3 free-running clocks -> PCValue 0x0, 0x4, 0x8, 0xC; assert reset low mid-cycle -> PCValue=0 immediately, async.
- PCValue=0x10, stall=1 for 2 cycles with branch_taken=1 -> PC stays 0x10; release -> branch_target 0x0040_0100 loads as 0x0000_0100 (masked).
- At PC 0x20, exception=1 with stall=1 -> PC 0x180, EPC 0x20, in_exception=1; second exception -> EPC still 0x20; eret -> PC 0x20, in_exception=0.
- 5 calls from PCs 0x100/0x200/0x300/0x400/0x500 -> ras_full=1; 4 rets -> targets 0x504, 0x404, 0x304, 0x204, then ras_empty=1; 5th ret with jump_target 0x40 -> PC 0x40.
- RAS holding {0x104}, call+ret at PC 0x300 -> PC 0x104, count 1, next ret -> 0x304.
- Priority: jump=1, branch_taken=1, jump_target 0x80, branch_target 0x90 -> PC 0x80; PC 0x000F_FFFC sequential -> 0x0000_0000.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: program counter for the MIPS fetch path.
// Holds the PC and selects the next PC by priority:
// exception, eret, ret, jump, branch, then sequential.
// Every loaded address is masked to the implemented address space.
// A small circular return-address stack serves call/ret.
// A two-state RUN/EXC machine holds the exception PC.
module pc_unit #(
    parameter int             N            = 32,
    parameter int             ADDR_BITS    = 20,
    parameter logic [N-1:0]   RESET_VECTOR = 32'h0000_0000,
    parameter logic [N-1:0]   EXC_VECTOR   = 32'h0000_0180,
    parameter int             RAS_DEPTH    = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    input  logic         jump,
    input  logic [N-1:0] jump_target,
    input  logic         call,
    input  logic         ret,
    input  logic         exception,
    input  logic         eret,
    output logic [N-1:0] PCValue,
    output logic [N-1:0] EPCValue,
    output logic         in_exception,
    output logic         ras_empty,
    output logic         ras_full
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Builds the mask of implemented address bits; upper bits read as zero.
    function automatic logic [N-1:0] build_mask();
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) begin
            m[i] = (i < ADDR_BITS) ? 1'b1 : 1'b0;
        end
        return m;
    endfunction

    localparam logic [N-1:0]     ADDR_MASK  = build_mask();
    localparam logic [N-1:0]     PC_STEP    = N'(4);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(RAS_DEPTH);
    localparam logic [N-1:0]     RST_PC     = RESET_VECTOR & ADDR_MASK;
    localparam logic [N-1:0]     EXC_PC     = EXC_VECTOR & ADDR_MASK;

    // Confines an address to the implemented address space.
    function automatic logic [N-1:0] mask_addr(input logic [N-1:0] a);
        return a & ADDR_MASK;
    endfunction

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_EXC = 1'b1
    } exc_state_t;

    // Registered state
    exc_state_t       r_state;
    logic [N-1:0]     r_pc;
    logic [N-1:0]     r_epc;
    logic [N-1:0]     r_ras [RAS_DEPTH];
    logic [PTR_W-1:0] r_ras_ptr;   // index of the current top entry
    logic [CNT_W-1:0] r_ras_cnt;   // number of valid entries

    // Combinational next-state signals
    exc_state_t       w_state_next;
    logic [N-1:0]     w_pc_next;
    logic [N-1:0]     w_epc_next;
    logic             w_push;
    logic             w_pop;
    logic             w_exc_take;
    logic             w_eret_take;
    logic             w_ras_empty;
    logic             w_ras_full;
    logic [N-1:0]     w_pc_seq;
    logic [N-1:0]     w_ras_top;
    logic [PTR_W-1:0] w_ptr_inc;
    logic [PTR_W-1:0] w_ptr_dec;

    // Qualified requests and shared helper values derived from registered state.
    always_comb begin
        w_exc_take  = exception && (r_state == ST_RUN);
        w_eret_take = eret && (r_state == ST_EXC) && !stall;
        w_ras_empty = (r_ras_cnt == '0);
        w_ras_full  = (r_ras_cnt == CNT_FULL);
        w_pc_seq    = mask_addr(r_pc + PC_STEP);
        w_ras_top   = r_ras[r_ras_ptr];
        w_ptr_inc   = r_ras_ptr + PTR_ONE;
        w_ptr_dec   = r_ras_ptr - PTR_ONE;
    end

    // Next-PC priority selection, exception FSM transitions and RAS requests.
    always_comb begin
        w_pc_next    = r_pc;
        w_epc_next   = r_epc;
        w_state_next = r_state;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        if (w_exc_take) begin
            // A trap is taken even while stalled and suppresses call/ret.
            w_pc_next    = EXC_PC;
            w_epc_next   = r_pc;
            w_state_next = ST_EXC;
        end else if (stall) begin
            w_pc_next    = r_pc;
        end else if (w_eret_take) begin
            w_pc_next    = r_epc;
            w_state_next = ST_RUN;
        end else begin
            w_push = call;
            w_pop  = ret;
            if (ret) begin
                if (w_ras_empty) begin
                    w_pc_next = mask_addr(jump_target);
                end else begin
                    w_pc_next = w_ras_top;
                end
            end else if (jump) begin
                w_pc_next = mask_addr(jump_target);
            end else if (branch_taken) begin
                w_pc_next = mask_addr(branch_target);
            end else begin
                w_pc_next = w_pc_seq;
            end
        end
    end

    // PC, EPC and exception-state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc    <= RST_PC;
            r_epc   <= '0;
            r_state <= ST_RUN;
        end else begin
            r_pc    <= w_pc_next;
            r_epc   <= w_epc_next;
            r_state <= w_state_next;
        end
    end

    // Return-address stack: circular storage, pointer and occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ras_ptr <= '0;
            r_ras_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    // Push; when full, the slot after the top is the oldest entry.
                    r_ras_ptr        <= w_ptr_inc;
                    r_ras[w_ptr_inc] <= w_pc_seq;
                    if (w_ras_full) begin
                        r_ras_cnt <= r_ras_cnt;
                    end else begin
                        r_ras_cnt <= r_ras_cnt + CNT_ONE;
                    end
                end
                2'b01: begin
                    if (!w_ras_empty) begin
                        r_ras_ptr <= w_ptr_dec;
                        r_ras_cnt <= r_ras_cnt - CNT_ONE;
                    end else begin
                        r_ras_cnt <= r_ras_cnt;
                    end
                end
                2'b11: begin
                    // Pop then push: the top is replaced in place.
                    if (!w_ras_empty) begin
                        r_ras[r_ras_ptr] <= w_pc_seq;
                    end else begin
                        r_ras_ptr        <= w_ptr_inc;
                        r_ras[w_ptr_inc] <= w_pc_seq;
                        r_ras_cnt        <= CNT_ONE;
                    end
                end
                default: begin
                    r_ras_cnt <= r_ras_cnt;
                end
            endcase
        end
    end

    assign PCValue      = r_pc;
    assign EPCValue     = r_epc;
    assign in_exception = (r_state == ST_EXC);
    assign ras_empty    = (r_ras_cnt == '0);
    assign ras_full     = (r_ras_cnt == CNT_FULL);

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: directed scenarios with literal expectations plus
// randomized traffic, all checked against a queue-based behavioural model.
module tb_pc_unit;

    localparam logic [31:0] MASK  = 32'h000F_FFFF;
    localparam logic [31:0] EXCV  = 32'h0000_0180;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        call;
    logic        ret;
    logic        exception;
    logic        eret;
    logic [31:0] PCValue;
    logic [31:0] EPCValue;
    logic        in_exception;
    logic        ras_empty;
    logic        ras_full;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    bit          m_exc;
    logic [31:0] m_ras[$];

    pc_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .call          (call),
        .ret           (ret),
        .exception     (exception),
        .eret          (eret),
        .PCValue       (PCValue),
        .EPCValue      (EPCValue),
        .in_exception  (in_exception),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc  = 32'h0;
        m_epc = 32'h0;
        m_exc = 1'b0;
        m_ras.delete();
    endtask

    // One architectural step of the PC from the current inputs.
    task automatic model_step();
        logic [31:0] seq;
        logic [31:0] tgt;
        bit          had;
        seq = (m_pc + 32'd4) & MASK;
        if (exception && !m_exc) begin
            m_epc = m_pc;
            m_pc  = EXCV;
            m_exc = 1'b1;
        end else if (!stall) begin
            if (eret && m_exc) begin
                m_pc  = m_epc;
                m_exc = 1'b0;
            end else begin
                had = (m_ras.size() > 0);
                if (ret)               tgt = had ? m_ras[$] : (jump_target & MASK);
                else if (jump)         tgt = jump_target & MASK;
                else if (branch_taken) tgt = branch_target & MASK;
                else                   tgt = seq;
                if (ret && had) void'(m_ras.pop_back());
                if (call) begin
                    if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
                    m_ras.push_back(seq);
                end
                m_pc = tgt;
            end
        end
    endtask

    // Compare process: advance the model on each edge and check every output.
    always @(posedge clk) begin
        if (reset) model_step();
        #1;
        check("pc", PCValue, m_pc);
        check("epc", EPCValue, m_epc);
        check("in_exc", {31'b0, in_exception}, {31'b0, m_exc});
        check("ras_empty", {31'b0, ras_empty}, {31'b0, (m_ras.size() == 0)});
        check("ras_full", {31'b0, ras_full}, {31'b0, (m_ras.size() == DEPTH)});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        jump = 1'b0; jump_target = 32'h0; call = 1'b0; ret = 1'b0;
        exception = 1'b0; eret = 1'b0;
    endtask

    task automatic goto(input logic [31:0] a);
        jump = 1'b1; jump_target = a;
        tick();
        jump = 1'b0;
        check("goto", PCValue, a & MASK);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        model_reset();
        tick();
        tick();
        reset = 1'b1;

        // Reset value and free-running increment
        check("rst_pc", PCValue, 32'h0);
        check("rst_empty", {31'b0, ras_empty}, 32'h1);
        check("rst_inexc", {31'b0, in_exception}, 32'h0);
        tick(); check("seq1", PCValue, 32'h4);
        tick(); check("seq2", PCValue, 32'h8);
        tick(); check("seq3", PCValue, 32'hC);
        // Asynchronous reset in mid-cycle
        reset = 1'b0;
        #1;
        check("async_rst_pc", PCValue, 32'h0);
        model_reset();
        tick();
        reset = 1'b1;

        // Stall holds the PC; released branch loads masked target
        goto(32'h10);
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0040_0100;
        tick(); check("stall1", PCValue, 32'h10);
        tick(); check("stall2", PCValue, 32'h10);
        stall = 1'b0;
        tick(); check("br_mask", PCValue, 32'h100);
        clear_inputs();

        // Exception under stall, ignored second exception, eret
        goto(32'h20);
        exception = 1'b1; stall = 1'b1;
        tick();
        check("exc_pc", PCValue, 32'h180);
        check("exc_epc", EPCValue, 32'h20);
        check("exc_flag", {31'b0, in_exception}, 32'h1);
        stall = 1'b0;
        tick();
        check("exc2_epc", EPCValue, 32'h20);
        check("exc2_pc", PCValue, 32'h184);
        exception = 1'b0; eret = 1'b1;
        tick();
        check("eret_pc", PCValue, 32'h20);
        check("eret_flag", {31'b0, in_exception}, 32'h0);
        clear_inputs();

        // RAS overflow and underflow
        for (int k = 1; k <= 5; k++) begin
            goto(32'(k) * 32'h100);
            call = 1'b1;
            tick();
            call = 1'b0;
        end
        check("ras_full", {31'b0, ras_full}, 32'h1);
        ret = 1'b1;
        tick(); check("ret1", PCValue, 32'h504);
        tick(); check("ret2", PCValue, 32'h404);
        tick(); check("ret3", PCValue, 32'h304);
        tick(); check("ret4", PCValue, 32'h204);
        check("ras_empty", {31'b0, ras_empty}, 32'h1);
        jump_target = 32'h40;
        tick(); check("ret_empty", PCValue, 32'h40);
        clear_inputs();

        // Simultaneous call and ret
        goto(32'h100);
        call = 1'b1; tick(); call = 1'b0;
        goto(32'h300);
        call = 1'b1; ret = 1'b1;
        tick();
        check("callret_pc", PCValue, 32'h104);
        check("callret_ne", {31'b0, ras_empty}, 32'h0);
        call = 1'b0;
        tick();
        check("callret_ret", PCValue, 32'h304);
        clear_inputs();

        // Priority and wrap
        jump = 1'b1; branch_taken = 1'b1; jump_target = 32'h80; branch_target = 32'h90;
        tick(); check("prio", PCValue, 32'h80);
        clear_inputs();
        goto(32'h000F_FFFC);
        tick(); check("wrap", PCValue, 32'h0);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            stall         = ($urandom_range(0, 99) < 20);
            exception     = ($urandom_range(0, 99) < 4);
            eret          = ($urandom_range(0, 99) < 12);
            call          = ($urandom_range(0, 99) < 15);
            ret           = ($urandom_range(0, 99) < 15);
            jump          = ($urandom_range(0, 99) < 10);
            branch_taken  = ($urandom_range(0, 99) < 15);
            jump_target   = ($urandom_range(0, 3) == 0) ? 32'h000F_FFF8 : 32'($urandom());
            branch_target = 32'($urandom());
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
                model_reset();
            end else begin
                reset = 1'b1;
            end
            tick();
        end
        clear_inputs();
        reset = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
